// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and sequencer sharing one UART transmitter among
// four requesters. A grant latches the winner's byte, strobes the
// transmitter, waits for completion (or a watchdog timeout) and then
// pulses ack to the winner. All outputs are registered.
module uart_tx_arbiter #(
  parameter int              N_REQ   = 4,
  parameter int              DW      = 8,
  parameter int              TO_W    = 16,
  parameter logic [TO_W-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    ack,
  output logic                err,
  output logic                tx_start,
  output logic [DW-1:0]       tx_data,
  input  logic                tx_done,
  output logic                busy,
  output logic [1:0]          owner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TO_W-1:0]   r_wdog;
  logic [1:0]        r_last_grant;
  logic [1:0]        r_owner;
  logic [DW-1:0]     r_tx_data;
  logic              r_tx_start;
  logic              r_busy;
  logic [N_REQ-1:0]  r_ack;
  logic              r_err;

  logic              w_found;
  logic [1:0]        w_winner;
  logic [1:0]        w_idx;
  logic [DW-1:0]     w_grant_data;
  logic              w_timeout;
  logic [N_REQ-1:0]  w_ack_vec;

  // Round-robin search: start one past the last grant and take the first
  // requester found. The 2-bit index wraps naturally modulo four.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // otherwise a path that skips the assignment infers a latch.
    w_found  = 1'b0;
    w_winner = r_last_grant;
    w_idx    = r_last_grant;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = r_last_grant + 2'(k);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Select the winner's byte out of the flattened request data bus.
  always_comb begin
    w_grant_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_winner == 2'(i)) begin
        w_grant_data = req_data[i*DW +: DW];
      end
    end
  end

  // Next-state logic; tx_done wins over a coincident watchdog expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          w_state_nxt = S_ACK;
        end else if (r_wdog == TIMEOUT) begin
          w_state_nxt = S_ACK;
          w_timeout   = 1'b1;
        end
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // One-hot ack for the current owner.
  always_comb begin
    w_ack_vec = N_REQ'(1) << r_owner;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every
      // register samples pre-edge values regardless of block ordering.
      r_state <= w_state_nxt;
    end
  end

  // Watchdog: cleared in START, counts every WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (r_state == S_START) begin
      r_wdog <= '0;
    end else if (r_state == S_WAIT) begin
      r_wdog <= r_wdog + TO_W'(1);
    end
  end

  // Grant bookkeeping: latch owner and byte on grant, rotate priority on ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= 2'd0;
      r_tx_data    <= '0;
      r_last_grant <= 2'd3;
    end else begin
      if (r_state == S_IDLE && w_found) begin
        r_owner   <= w_winner;
        r_tx_data <= w_grant_data;
      end
      if (r_state == S_ACK) begin
        r_last_grant <= r_owner;
      end
    end
  end

  // Registered strobes decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_ack      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_tx_start <= (w_state_nxt == S_START);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_ack      <= (w_state_nxt == S_ACK) ? w_ack_vec : '0;
      r_err      <= w_timeout;
    end
  end

  assign ack      = r_ack;
  assign err      = r_err;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign busy     = r_busy;
  assign owner    = r_owner;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a table of hand-computed
// transactions, a reset-during-WAIT sequence, and randomized transactions
// checked against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int N_REQ = 4;
  localparam int DW    = 8;
  localparam int TO_W  = 16;
  localparam int TMO   = 8;

  logic                clk;
  logic                rst_n;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    ack;
  logic                err;
  logic                tx_start;
  logic [DW-1:0]       tx_data;
  logic                tx_done;
  logic                busy;
  logic [1:0]          owner;

  int n_checks = 0;
  int n_errors = 0;
  int model_last = 3;

  uart_tx_arbiter #(
    .N_REQ  (N_REQ),
    .DW     (DW),
    .TO_W   (TO_W),
    .TIMEOUT(16'(TMO))
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_data(req_data),
    .ack     (ack),
    .err     (err),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_done (tx_done),
    .busy    (busy),
    .owner   (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  typedef struct {
    bit          rst_before;
    logic [3:0]  req;
    logic [31:0] data;
    int          done_at;   // cycle tx_done pulses (-1: never)
    int          spur;      // extra tx_done pulse that must be ignored (-1: none)
    logic [1:0]  exp_owner;
    logic [7:0]  exp_data;
    bit          exp_err;
    int          exp_ack;   // cycle of ack relative to req cycle 0
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: search from last+1 upward, first set bit wins.
  function automatic logic [1:0] model_arb(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (r[i]) return 2'(i);
    end
    return 2'(last);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, ".tx_start"}, 32'(tx_start), 0);
    check({tag, ".tx_data"},  32'(tx_data),  0);
    check({tag, ".ack"},      32'(ack),      0);
    check({tag, ".err"},      32'(err),      0);
    check({tag, ".busy"},     32'(busy),     0);
    check({tag, ".owner"},    32'(owner),    0);
  endtask

  task automatic do_reset(input string tag);
    req     = '0;
    tx_done = 1'b0;
    rst_n   = 1'b0;
    repeat (3) step();
    check_reset_outputs(tag);
    rst_n      = 1'b1;
    model_last = 3;
  endtask

  // One transaction: cycle 0 is an IDLE cycle in which req is applied.
  task automatic run_txn(input string tag, input logic [3:0] r, input logic [31:0] d,
                         input int done_at, input int spur,
                         input logic [1:0] e_owner, input logic [7:0] e_data,
                         input bit e_err, input int e_ack);
    int         start_cnt;
    int         start_cyc;
    int         ack_cyc;
    logic [3:0] ack_val;
    logic       err_val;
    logic [7:0] d_start;
    logic [1:0] o_start;
    bit         busy_ok;
    bit         data_ok;
    bit         stray_err;
    start_cnt = 0;
    start_cyc = -1;
    ack_cyc   = -1;
    ack_val   = 'x;
    err_val   = 'x;
    d_start   = 'x;
    o_start   = 'x;
    busy_ok   = 1'b1;
    data_ok   = 1'b1;
    stray_err = 1'b0;
    step();
    check({tag, ".idle_busy"}, 32'(busy), 0);
    req      = r;
    req_data = d;
    tx_done  = (spur == 0);
    for (int c = 1; c <= TMO + 8 && ack_cyc < 0; c++) begin
      step();
      tx_done = (c == done_at) || (c == spur);
      if (tx_start) begin
        start_cnt++;
        if (start_cyc < 0) begin
          start_cyc = c;
          d_start   = tx_data;
          o_start   = owner;
        end
      end
      if (!busy) busy_ok = 1'b0;
      if (start_cyc >= 0 && tx_data !== d_start) data_ok = 1'b0;
      if (ack != '0) begin
        ack_cyc = c;
        ack_val = ack;
        err_val = err;
      end else if (err) begin
        stray_err = 1'b1;
      end
    end
    tx_done = 1'b0;
    check({tag, ".start_cycle"}, 32'(start_cyc), 1);
    check({tag, ".start_count"}, 32'(start_cnt), 1);
    check({tag, ".owner"},       32'(o_start),   32'(e_owner));
    check({tag, ".tx_data"},     32'(d_start),   32'(e_data));
    check({tag, ".ack_cycle"},   32'(ack_cyc),   32'(e_ack));
    check({tag, ".ack"},         32'(ack_val),   32'(4'b0001 << e_owner));
    check({tag, ".err"},         32'(err_val),   32'(e_err));
    check({tag, ".busy_window"}, 32'(busy_ok),   1);
    check({tag, ".data_stable"}, 32'(data_ok),   1);
    check({tag, ".stray_err"},   32'(stray_err), 0);
  endtask

  task automatic idle_cycles(input int n);
    req = '0;
    for (int i = 0; i < n; i++) begin
      step();
      check("idle.busy", 32'(busy), 0);
    end
  endtask

  initial begin
    bit         quiet;
    logic [3:0] r;
    logic [31:0] d;
    int         done_at;
    int         spur;
    logic [1:0] e_owner;

    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    tx_done  = 1'b0;

    tbl[0]  = '{1'b1, 4'b0001, 32'h0000005A,  6, -1, 2'd0, 8'h5A, 1'b0,  7};
    tbl[1]  = '{1'b1, 4'b1111, 32'h43322110,  2, -1, 2'd0, 8'h10, 1'b0,  3};
    tbl[2]  = '{1'b0, 4'b1111, 32'h43322110,  3,  1, 2'd1, 8'h21, 1'b0,  4};
    tbl[3]  = '{1'b0, 4'b1111, 32'h43322110,  5,  0, 2'd2, 8'h32, 1'b0,  6};
    tbl[4]  = '{1'b0, 4'b1111, 32'h43322110, 10, -1, 2'd3, 8'h43, 1'b0, 11};
    tbl[5]  = '{1'b0, 4'b1111, 32'h43322110, -1, -1, 2'd0, 8'h10, 1'b1, 11};
    tbl[6]  = '{1'b0, 4'b0100, 32'h44332211,  4, -1, 2'd2, 8'h33, 1'b0,  5};
    tbl[7]  = '{1'b0, 4'b0101, 32'h44332211,  2, -1, 2'd0, 8'h11, 1'b0,  3};
    tbl[8]  = '{1'b0, 4'b0101, 32'h44332211,  9, -1, 2'd2, 8'h33, 1'b0, 10};
    tbl[9]  = '{1'b1, 4'b1000, 32'hA5000000,  7, -1, 2'd3, 8'hA5, 1'b0,  8};
    tbl[10] = '{1'b0, 4'b0110, 32'h44332211,  2, -1, 2'd1, 8'h22, 1'b0,  3};
    tbl[11] = '{1'b0, 4'b1001, 32'h44332211, -1, -1, 2'd3, 8'h44, 1'b1, 11};

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rst_before) do_reset($sformatf("row%0d.reset", i));
      run_txn($sformatf("row%0d", i), tbl[i].req, tbl[i].data, tbl[i].done_at,
              tbl[i].spur, tbl[i].exp_owner, tbl[i].exp_data, tbl[i].exp_err,
              tbl[i].exp_ack);
    end
    idle_cycles(2);

    // Reset asserted while in WAIT: outputs clear at once, no ack follows,
    // and requester 0 regains top priority.
    step();
    req      = 4'b0010;
    req_data = 32'h00007700;
    repeat (3) step();
    check("midwait.busy_before", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midwait.async");
    req = '0;
    repeat (2) step();
    rst_n      = 1'b1;
    model_last = 3;
    quiet      = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ack != '0 || err || busy || tx_start) quiet = 1'b0;
    end
    check("midwait.no_ack", 32'(quiet), 1);
    run_txn("midwait.after", 4'b1111, 32'h0D0C0B0A, 3, -1, 2'd0, 8'h0A, 1'b0, 4);
    model_last = 0;

    // Randomized transactions against the round-robin model.
    for (int n = 0; n < 40; n++) begin
      r = 4'($urandom_range(1, 15));
      d = $urandom;
      if ($urandom_range(0, 7) == 0) done_at = -1;
      else done_at = int'($urandom_range(2, TMO + 2));
      spur    = int'($urandom_range(0, 2)) - 1;
      e_owner = model_arb(model_last, r);
      run_txn($sformatf("rand%0d", n), r, d, done_at, spur, e_owner,
              d[e_owner*8 +: 8], (done_at < 0),
              (done_at < 0) ? TMO + 3 : done_at + 1);
      model_last = int'(e_owner);
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end

    idle_cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter among up to four requesters. It accepts byte requests, grants the transmitter to one requester at a time and drives the transmitter's start strobe and data byte. It waits for the transmitter's completion pulse, or a watchdog timeout, and then acknowledges the granted requester. It sits between the client logic and the UART top, beside the baud-rate divisor configuration.

## Interface
- N_REQ, 4: number of requesters; fixed at 4 in this revision (2-bit owner index).
- DW, 8: data byte width; matches the transmitter data input.
- TO_W, 16: width of the watchdog counter.
- TIMEOUT, 16'hFFFF: maximum WAIT cycles before abort. Must exceed 10 bit-times at the slowest divisor in use.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request level.
- req_data  in  N_REQ*DW  flattened request bytes; requester i occupies bits [i*DW +: DW].
- ack  out  N_REQ  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle pulse, coincident with ack, when the transfer timed out.
- tx_start  out  1  one-cycle start strobe to the transmitter.
- tx_data  out  DW  byte to the transmitter; held stable from START until return to IDLE.
- tx_done  in  1  transmitter completion pulse, one cycle wide.
- busy  out  1  high whenever the state is not IDLE.
- owner  out  2  index of the current or last granted requester.

## Operation
- FSM states:
  - IDLE → START: taken when any req bit is high. The arbiter chooses the winner, loads tx_data from the winner's slice of req_data and sets owner to the winner.
  - START: tx_start = 1; clear the watchdog. Always moves to WAIT. tx_done is ignored in this state.
  - WAIT: the watchdog increments each cycle.
    - tx_done = 1: go to ACK with no error.
    - Watchdog == TIMEOUT and tx_done = 0: go to ACK and set the error flag.
    - tx_done has priority over a simultaneous timeout.
  - ACK: ack[owner] = 1 and err = error flag; last_grant ← owner. Always moves to IDLE.
- Round-robin arbitration:
  - Search starts at (last_grant+1) mod 4 and increments; the first set req bit wins.
  - last_grant resets to 3, so requester 0 has top priority after reset.
- Requester contract:
  - Hold req high and req_data stable until ack is seen.
  - Deassert req on the clock edge that samples ack, so req is low in the cycle after ACK.
  - A requester that keeps req high re-enters arbitration at lowest priority.
- tx_done is ignored in IDLE and in ACK.
- req changes in START, WAIT and ACK have no effect; the latched byte is used.
- All outputs are registered.
- Reset values: tx_start 0, tx_data 0, ack 0, err 0, busy 0, owner 0, state IDLE, watchdog 0, last_grant 3.
- Reset asserted mid-transfer: the FSM returns to IDLE at once with no ack. Any transmitter activity is not tracked.

## Timing
- Let req rise in cycle 0 while in IDLE:
  - START in cycle 1: tx_start high and tx_data valid.
  - WAIT from cycle 2.
  - If tx_done arrives in cycle k (k ≥ 2), ACK is in cycle k+1 and IDLE in cycle k+2.
- Minimum req-to-ack latency is 3 cycles.
- Back-to-back transfers: the next START is 2 cycles after ACK (IDLE, then START).
- Timeout path: with no tx_done, err and ack assert in cycle TIMEOUT+3.
- busy is high from cycle 1 through the ACK cycle inclusive.
- tx_start is high for exactly 1 cycle per grant.
- ack is exactly 1 cycle wide, and exactly one ack bit is high in that cycle.

## Test plan
- Single request:
  - Stimulus: rst_n low for 3 cycles, then req=4'b0001 with byte 0 = 8'h5A; tx_done pulses 5 cycles after tx_start.
  - Required: tx_start pulse in cycle 1 with tx_data=8'h5A; ack=4'b0001 with err=0 one cycle after tx_done; busy low afterwards.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held continuously, bytes 8'h10/8'h21/8'h32/8'h43.
  - Required: grant order 0,1,2,3,0; tx_data sequence 10,21,32,43,10.
- Priority rotation:
  - Stimulus: grant requester 2, then raise req=4'b0101.
  - Required: requester 0 wins next, not requester 2.
- Timeout:
  - Stimulus: TIMEOUT=8, single request, tx_done never asserted.
  - Required: ack and err both high in cycle 11 relative to req, then IDLE.
- Simultaneous tx_done and timeout:
  - Stimulus: tx_done pulsed on the cycle the watchdog equals TIMEOUT.
  - Required: ack high with err=0.
- Reset mid-WAIT:
  - Stimulus: drop rst_n while in WAIT.
  - Required: all outputs return to reset values immediately; no ack follows; after release, requester 0 has top priority.
